issue_scoreboard: RTL

//   In-order issue controller for the OoO pipeline. It tracks which architectural

---
 rtl/issue_scoreboard_if.sv | 58 +++++
 rtl/issue_scoreboard.sv | 100 ++++++++++
 2 files changed

// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue request, hazard status and writeback events.
// Latency: none, wires only.
// Backpressure: issue_ready_o is the accept signal back to decode (fire = valid & ready).
//
// Signals (names mirror the scoreboard's port list):
//   issue_valid_i/issue_ready_o      issue handshake
//   rs1/rs2/rd_addr_i, uses_*/writes  operand descriptors of the presented instruction
//   fu_id_i, fu_busy_i               target FU and per-FU cannot-accept flags
//   wb_valid_i/wb_addr_i/wb_fu_id_i  writeback event
//   flush_i                          discard all pending ownership
//   busy_vec_o, pending_count_o      registered busy bits and their popcount
//   stall_*_o, wb_mismatch_o         hazard reasons and stale-writeback pulse
interface issue_scoreboard_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FU_ID_WIDTH    = 2
);
    localparam int ENTRIES = 2**REG_ADDR_WIDTH;
    localparam int NUM_FU  = 2**FU_ID_WIDTH;

    logic                      issue_valid_i;
    logic                      issue_ready_o;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_i;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_i;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
    logic                      uses_rs1_i;
    logic                      uses_rs2_i;
    logic                      writes_rd_i;
    logic [FU_ID_WIDTH-1:0]    fu_id_i;
    logic [NUM_FU-1:0]         fu_busy_i;
    logic                      wb_valid_i;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_i;
    logic [FU_ID_WIDTH-1:0]    wb_fu_id_i;
    logic                      flush_i;
    logic [ENTRIES-1:0]        busy_vec_o;
    logic [REG_ADDR_WIDTH:0]   pending_count_o;
    logic                      stall_raw_o;
    logic                      stall_waw_o;
    logic                      stall_struct_o;
    logic                      wb_mismatch_o;

    // Decode / writeback side.
    modport master (
        output issue_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
               uses_rs1_i, uses_rs2_i, writes_rd_i, fu_id_i, fu_busy_i,
               wb_valid_i, wb_addr_i, wb_fu_id_i, flush_i,
        input  issue_ready_o, busy_vec_o, pending_count_o,
               stall_raw_o, stall_waw_o, stall_struct_o, wb_mismatch_o
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
               uses_rs1_i, uses_rs2_i, writes_rd_i, fu_id_i, fu_busy_i,
               wb_valid_i, wb_addr_i, wb_fu_id_i, flush_i,
        output issue_ready_o, busy_vec_o, pending_count_o,
               stall_raw_o, stall_waw_o, stall_struct_o, wb_mismatch_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register busy bit + owning FU, stalls on RAW/WAW/FU-busy.
// Latency: issue-to-busy and writeback-to-free each visible 1 cycle later; hazards are comb.
// Backpressure: issue_ready_o drops on any hazard or flush, independent of issue_valid_i.
//
// Ports: clk, rst (async active-high), sb (issue_scoreboard_if.slave: issue handshake,
// operand descriptors, FU busy flags, writeback, flush, busy/pending/stall/mismatch status).
module issue_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FU_ID_WIDTH    = 2
) (
    input logic               clk,
    input logic               rst,
    issue_scoreboard_if.slave sb
);
    localparam int ENTRIES = 2**REG_ADDR_WIDTH;
    localparam int CNT_W   = REG_ADDR_WIDTH + 1;

    typedef logic [FU_ID_WIDTH-1:0] fu_t;

    logic [ENTRIES-1:0] busy_q;
    logic [ENTRIES-1:0] busy_d;
    fu_t                owner_q [ENTRIES];
    fu_t                owner_d [ENTRIES];
    logic               wb_mismatch_q;
    logic               wb_mismatch_d;

    logic               raw;
    logic               waw;
    logic               strct;
    logic               fire;
    logic               set_en;
    logic               wb_live;
    logic               wb_hit;
    logic [CNT_W-1:0]   pending;

    // Hazards look only at registered state: the register file returns the
    // pre-write value on a same-cycle writeback, so no bypass is allowed.
    assign raw   = (sb.uses_rs1_i && (sb.rs1_addr_i != '0) && busy_q[sb.rs1_addr_i]) ||
                   (sb.uses_rs2_i && (sb.rs2_addr_i != '0) && busy_q[sb.rs2_addr_i]);
    assign waw   = sb.writes_rd_i && (sb.rd_addr_i != '0) && busy_q[sb.rd_addr_i];
    assign strct = sb.fu_busy_i[sb.fu_id_i];

    assign sb.issue_ready_o  = !raw && !waw && !strct && !sb.flush_i;
    assign sb.stall_raw_o    = sb.issue_valid_i && raw;
    assign sb.stall_waw_o    = sb.issue_valid_i && waw;
    assign sb.stall_struct_o = sb.issue_valid_i && strct;

    assign fire    = sb.issue_valid_i && sb.issue_ready_o;
    assign set_en  = fire && sb.writes_rd_i && (sb.rd_addr_i != '0);
    assign wb_live = sb.wb_valid_i && (sb.wb_addr_i != '0);
    // Only the current owner may retire a busy register; anything else is stale.
    assign wb_hit  = wb_live && busy_q[sb.wb_addr_i] &&
                     (owner_q[sb.wb_addr_i] == sb.wb_fu_id_i);

    always_comb begin
        busy_d        = busy_q;
        owner_d       = owner_q;
        wb_mismatch_d = 1'b0;
        if (sb.flush_i) begin
            // Owners are left as-is; they are meaningless once busy is clear.
            busy_d = '0;
        end else begin
            if (wb_hit) begin
                busy_d[sb.wb_addr_i] = 1'b0;
            end
            wb_mismatch_d = wb_live && !wb_hit;
            // Applied after the clear so a same-register collision keeps it busy.
            if (set_en) begin
                busy_d[sb.rd_addr_i]  = 1'b1;
                owner_d[sb.rd_addr_i] = sb.fu_id_i;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            wb_mismatch_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            busy_q        <= busy_d;
            wb_mismatch_q <= wb_mismatch_d;
            owner_q       <= owner_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            pending = pending + CNT_W'(busy_q[i]);
        end
    end

    assign sb.busy_vec_o      = busy_q;
    assign sb.pending_count_o = pending;
    assign sb.wb_mismatch_o   = wb_mismatch_q;
endmodule
